ir_nec_tx: RTL and testbench
============================

# ir_nec_tx

Infrared transmitter; the other end of the IR link from the sensor receiver. On a one-cycle start request it serialises an 8-bit address and 8-bit command into a NEC-format frame. The frame is amplitude-modulated onto a carrier and drives the IR LED pin. It sits beside the receiver in the same clock domain, and its status LED mirrors the receiver's indicator style.

## Interface
- CARRIER_HALF, 658: clock cycles per carrier half-period (50 MHz / 76 kHz ≈ 38 kHz carrier); minimum 1.
- UNIT_CYCLES, 28125: clock cycles per NEC time unit (562.5 µs at 50 MHz); minimum 1.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- start  in  1  transmit request; sampled only when idle.
- addr  in  8  address byte; captured at accepted start.
- cmd  in  8  command byte; captured at accepted start.
- busy  out  1  high from accepted start until frame end.
- done  out  1  one-cycle pulse at frame end.
- ir_out  out  1  modulated LED drive: envelope AND carrier.
- envelope  out  1  unmodulated mark(1)/space(0) envelope, for debug and loopback.
- led  out  1  status LED; equals busy.

## Operation
- Reset (reset=0 at an edge): state IDLE; busy, done, ir_out, envelope and led are 0; all counters are 0. Reset has priority over everything, including an in-flight frame. A frame aborted by reset produces no done pulse.
- Frame order: leader mark of 16 units, leader space of 8 units, then 32 data bits, then a stop mark of 1 unit.
- Data word is {~cmd, cmd, ~addr, addr}, sent LSB first: addr bit 0 first, ~cmd bit 7 last.
- Bit 0: 1-unit mark + 1-unit space. Bit 1: 1-unit mark + 3-unit space.
- States: IDLE, LDR_MARK, LDR_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK.
- Transitions:
  - IDLE→LDR_MARK on start=1.
  - LDR_MARK→LDR_SPACE after 16 units.
  - LDR_SPACE→BIT_MARK after 8 units.
  - BIT_MARK→BIT_SPACE after 1 unit.
  - BIT_SPACE→BIT_MARK after 1 or 3 units while bits remain; BIT_SPACE→STOP_MARK after the 32nd bit.
  - STOP_MARK→IDLE after 1 unit.
- Counters:
  - Cycle counter runs 0..UNIT_CYCLES-1.
  - Unit counter counts units within the current segment.
  - Bit index runs 0..31, 6 bits wide.
  - Shift register is 32 bits and shifts right after each BIT_SPACE.
- envelope = 1 in LDR_MARK, BIT_MARK and STOP_MARK; 0 in all other states.
- Carrier:
  - Counter runs 0..CARRIER_HALF-1; the phase bit toggles at wrap.
  - On every space→mark or IDLE→mark transition, the counter is forced to 0 and the phase to 1, so each mark begins with a full high half-period.
  - ir_out is 0 whenever envelope is 0.
- start while busy is ignored; addr and cmd are not re-captured.
- start asserted on the same edge as done goes high is ignored; the block is not IDLE until the following cycle.
- addr and cmd changes after capture have no effect on the current frame.

## Timing
- All outputs are registered.
- start sampled high in IDLE at edge E:
  - busy, led, envelope and ir_out are 1 after E.
  - First mark cycle is the cycle after E.
- Segment of N units = exactly N×UNIT_CYCLES clock cycles, with no gaps between segments.
- Frame length in units = 16 + 8 + Σbits(2 or 4) + 1.
- Frame end:
  - At the edge completing STOP_MARK, busy, led and envelope drop to 0 and done rises.
  - done falls at the next edge.
- Earliest restart: start sampled at the edge one cycle after done's edge is accepted.
- Carrier period = 2×CARRIER_HALF cycles with 50% duty. A mark of length L cycles shows ceil(L/CARRIER_HALF) phase segments, with the first segment high.

## Test plan
All scenarios use CARRIER_HALF=2, UNIT_CYCLES=8.
- Reset:
  - Hold reset=0 for 3 edges with start=1.
  - Required: all outputs 0; busy never rises.
  - Release reset with start=0; outputs stay 0.
- Frame 0x00/0x00:
  - Pulse start with addr=0x00, cmd=0x00.
  - Required: frame of 121 units = 968 cycles.
  - Envelope high for the first 128 cycles, then low for 64.
  - First data bit: 8-cycle mark then 8-cycle space.
  - done pulses exactly once, one cycle wide, at cycle 968 after acceptance.
- Frame 0xFF/0x5A:
  - Pulse start with addr=0xFF, cmd=0x5A.
  - Required: decode envelope bits as 0xA55A00FF ({~cmd, cmd, ~addr, addr}, LSB first).
  - Bit-1 spaces are 24 cycles; bit-0 spaces are 8 cycles.
  - Total units = 24 + 16×4 + 16×2 + 1 = 121.
- Carrier shape:
  - During the leader mark, check ir_out = 1,1,0,0 repeating.
  - At the start of every mark, ir_out restarts high for 2 cycles.
  - ir_out is 0 throughout every space.
- Start collisions:
  - Assert start again mid-frame with different addr and cmd; the frame content is unchanged.
  - Assert start in the done cycle; it is ignored.
  - Assert start one cycle later; it is accepted.
- Reset mid-frame:
  - Drop reset during BIT_SPACE of bit 10.
  - Required: all outputs 0 on the next edge and no done.
  - A new start after release produces a complete, correct frame.

Source files
------------

// File: rtl/ir_nec_tx.sv
// NEC-format IR transmitter: serialises {~cmd, cmd, ~addr, addr} LSB first as a
// mark/space envelope and gates it with a square-wave carrier for the LED.
module ir_nec_tx #(
    parameter int unsigned CARRIER_HALF = 658,
    parameter int unsigned UNIT_CYCLES  = 28125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] cmd,
    output logic       busy,
    output logic       done,
    output logic       ir_out,
    output logic       envelope,
    output logic       led
);

    localparam int unsigned CycW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int unsigned CarW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam logic [CycW-1:0] CycLast = CycW'(UNIT_CYCLES - 1);
    localparam logic [CarW-1:0] CarLast = CarW'(CARRIER_HALF - 1);

    typedef enum logic [2:0] {
        StIdle, StLdrMark, StLdrSpace, StBitMark, StBitSpace, StStopMark
    } state_e;

    state_e          state_q, state_d;
    logic [CycW-1:0] cyc_q, cyc_d;
    logic [4:0]      unit_q, unit_d;
    logic [5:0]      bit_idx_q, bit_idx_d;
    logic [31:0]     shift_q, shift_d;
    logic [CarW-1:0] car_cnt_q, car_cnt_d;
    logic            phase_q, phase_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            env_q, env_d;
    logic            ir_q, ir_d;

    logic [4:0] seg_units;
    logic       unit_end, seg_end, accept, mark_q, mark_d;

    function automatic logic is_mark(input state_e s);
        return (s == StLdrMark) || (s == StBitMark) || (s == StStopMark);
    endfunction

    always_comb begin
        case (state_q)
            StLdrMark:  seg_units = 5'd16;
            StLdrSpace: seg_units = 5'd8;
            StBitSpace: seg_units = shift_q[0] ? 5'd3 : 5'd1;
            default:    seg_units = 5'd1;
        endcase
    end

    assign unit_end = (cyc_q == CycLast);
    assign seg_end  = unit_end && (unit_q == seg_units - 5'd1);
    assign accept   = (state_q == StIdle) && start;
    assign mark_q   = is_mark(state_q);
    assign mark_d   = is_mark(state_d);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cyc_q     <= '0;
            unit_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            car_cnt_q <= '0;
            phase_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            env_q     <= 1'b0;
            ir_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            unit_q    <= unit_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            car_cnt_q <= car_cnt_d;
            phase_q   <= phase_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            env_q     <= env_d;
            ir_q      <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (start) state_d = StLdrMark;
            StLdrMark:  if (seg_end) state_d = StLdrSpace;
            StLdrSpace: if (seg_end) state_d = StBitMark;
            StBitMark:  if (seg_end) state_d = StBitSpace;
            StBitSpace: if (seg_end) state_d = (bit_idx_q == 6'd31) ? StStopMark : StBitMark;
            StStopMark: if (seg_end) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Segment timing and payload shifting.
    always_comb begin
        cyc_d     = cyc_q;
        unit_d    = unit_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        if (accept) begin
            cyc_d     = '0;
            unit_d    = '0;
            bit_idx_d = '0;
            shift_d   = {~cmd, cmd, ~addr, addr};
        end else if (state_q != StIdle) begin
            if (unit_end) begin
                cyc_d  = '0;
                unit_d = seg_end ? 5'd0 : unit_q + 5'd1;
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
            if (state_q == StBitSpace && seg_end) begin
                bit_idx_d = (bit_idx_q == 6'd31) ? 6'd0 : bit_idx_q + 6'd1;
                shift_d   = shift_q >> 1;
            end
        end
    end

    // Every mark restarts the carrier so it opens with a full high half-period.
    always_comb begin
        if (mark_d && !mark_q) begin
            car_cnt_d = '0;
            phase_d   = 1'b1;
        end else if (car_cnt_q == CarLast) begin
            car_cnt_d = '0;
            phase_d   = ~phase_q;
        end else begin
            car_cnt_d = car_cnt_q + 1'b1;
            phase_d   = phase_q;
        end
        env_d  = mark_d;
        ir_d   = mark_d & phase_d;
        busy_d = (state_d != StIdle);
        done_d = (state_q == StStopMark) && seg_end;
    end

    assign busy     = busy_q;
    assign led      = busy_q;
    assign done     = done_q;
    assign envelope = env_q;
    assign ir_out   = ir_q;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Self-checking bench for ir_nec_tx against a frame-level envelope/carrier model.
module tb_ir_nec_tx;

    localparam int CH = 2;
    localparam int UC = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b1;
    logic [7:0] addr = 8'h00;
    logic [7:0] cmd = 8'h00;
    logic       busy, done, ir_out, envelope, led;

    int n_cmp = 0;
    int n_err = 0;

    ir_nec_tx #(.CARRIER_HALF(CH), .UNIT_CYCLES(UC)) dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .cmd(cmd),
        .busy(busy), .done(done), .ir_out(ir_out), .envelope(envelope), .led(led)
    );

    always #5 clk = ~clk;

    // Vector order everywhere: {busy, led, done, envelope, ir_out}
    task automatic start_frame(input logic [7:0] a, input logic [7:0] c);
        addr  = a;
        cmd   = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        addr  = 8'($urandom);
        cmd   = 8'($urandom);
    endtask

    // Entered #1 after the accepting edge. poke>=0 re-asserts start mid-frame;
    // hold leaves start high (with na/nc) through the done edge; abort resets in bit 10 space.
    task automatic check_frame(input logic [7:0] a, input logic [7:0] c, input int poke,
                               input bit hold, input logic [7:0] na, input logic [7:0] nc,
                               input bit abort, output logic [31:0] dec);
        logic [31:0] w;
        bit          e[$];
        bit          ir[$];
        bit          tr[$];
        int          len, k, idx, ab, n;
        logic [4:0]  got, exp;
        w = {~c, c, ~a, a};
        repeat (16 * UC) e.push_back(1'b1);
        repeat (8 * UC) e.push_back(1'b0);
        for (int b = 0; b < 32; b++) begin
            repeat (UC) e.push_back(1'b1);
            repeat ((w[b] ? 3 : 1) * UC) e.push_back(1'b0);
        end
        repeat (UC) e.push_back(1'b1);
        len = e.size();
        k = 0;
        for (int i = 0; i < len; i++) begin
            if (e[i] && (i == 0 || !e[i-1])) k = 0;
            else if (e[i]) k++;
            ir.push_back(e[i] && ((k / CH) % 2 == 0));
        end
        ab = 24 * UC;
        for (int b = 0; b < 10; b++) ab += UC + (w[b] ? 3 : 1) * UC;
        ab += UC + 2;
        dec = '0;
        for (int i = 0; i < len; i++) begin
            got = {busy, led, done, envelope, ir_out};
            exp = {1'b1, 1'b1, 1'b0, e[i], ir[i]};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL frame a=%h c=%h cyc=%0d got=%b exp=%b", a, c, i, got, exp);
            end
            tr.push_back(envelope);
            if (abort && i == ab) begin
                reset = 1'b0;
                @(posedge clk); #1;
                got = {busy, led, done, envelope, ir_out};
                n_cmp++;
                if (got !== 5'b0) begin
                    n_err++;
                    $display("FAIL abort_reset got=%b exp=00000", got);
                end
                reset = 1'b1;
                for (int j = 0; j < 20; j++) begin
                    @(posedge clk); #1;
                    n_cmp++;
                    if ({busy, done} !== 2'b00) begin
                        n_err++;
                        $display("FAIL abort_quiet cyc=%0d busy/done=%b exp=00", j, {busy, done});
                    end
                end
                return;
            end
            if (i == poke) begin
                start = 1'b1;
                addr  = 8'($urandom);
                cmd   = 8'($urandom);
            end
            if (poke >= 0 && i == poke + 1) start = 1'b0;
            if (hold && i == len - 1) begin
                start = 1'b1;
                addr  = na;
                cmd   = nc;
            end
            @(posedge clk); #1;
        end
        got = {busy, led, done, envelope, ir_out};
        n_cmp++;
        if (got !== 5'b00100) begin
            n_err++;
            $display("FAIL done_edge a=%h c=%h got=%b exp=00100", a, c, got);
        end
        idx = 24 * UC;
        for (int b = 0; b < 32; b++) begin
            idx += UC;
            n = 0;
            while (idx < tr.size() && !tr[idx]) begin
                n++;
                idx++;
            end
            dec[b] = (n > 2 * UC);
        end
        n_cmp++;
        if (dec !== w) begin
            n_err++;
            $display("FAIL decode got=%h exp=%h", dec, w);
        end
        if (!hold) begin
            @(posedge clk); #1;
            got = {busy, led, done, envelope, ir_out};
            n_cmp++;
            if (got !== 5'b0) begin
                n_err++;
                $display("FAIL after_done got=%b exp=00000", got);
            end
        end
    endtask

    task automatic test_reset();
        logic [4:0] got;
        addr = 8'($urandom);
        cmd  = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            got = {busy, led, done, envelope, ir_out};
            n_cmp++;
            if (got !== 5'b0) begin
                n_err++;
                $display("FAIL reset_hold edge=%0d got=%b exp=00000", i, got);
            end
        end
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            got = {busy, led, done, envelope, ir_out};
            n_cmp++;
            if (got !== 5'b0) begin
                n_err++;
                $display("FAIL reset_release edge=%0d got=%b exp=00000", i, got);
            end
        end
    endtask

    task automatic test_frame_zero();
        logic [31:0] d;
        start_frame(8'h00, 8'h00);
        check_frame(8'h00, 8'h00, -1, 1'b0, 8'h00, 8'h00, 1'b0, d);
    endtask

    task automatic test_frame_ff5a();
        logic [31:0] d;
        start_frame(8'hFF, 8'h5A);
        check_frame(8'hFF, 8'h5A, -1, 1'b0, 8'h00, 8'h00, 1'b0, d);
        n_cmp++;
        if (d !== 32'hA55A00FF) begin
            n_err++;
            $display("FAIL ff5a_word got=%h exp=a55a00ff", d);
        end
    endtask

    task automatic test_random_frames();
        logic [31:0] d;
        logic [7:0]  a, c;
        for (int f = 0; f < 3; f++) begin
            a = 8'($urandom);
            c = 8'($urandom);
            start_frame(a, c);
            check_frame(a, c, -1, 1'b0, 8'h00, 8'h00, 1'b0, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [7:0]  a, c, na, nc;
        a  = 8'($urandom);
        c  = 8'($urandom);
        na = ~a;
        nc = 8'($urandom);
        start_frame(a, c);
        check_frame(a, c, 300, 1'b1, na, nc, 1'b0, d);
        @(posedge clk); #1;
        start = 1'b0;
        addr  = 8'($urandom);
        cmd   = 8'($urandom);
        check_frame(na, nc, -1, 1'b0, 8'h00, 8'h00, 1'b0, d);
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        logic [7:0]  a, c;
        a = 8'($urandom);
        c = 8'($urandom);
        start_frame(a, c);
        check_frame(a, c, -1, 1'b0, 8'h00, 8'h00, 1'b1, d);
        a = 8'($urandom);
        c = 8'($urandom);
        start_frame(a, c);
        check_frame(a, c, -1, 1'b0, 8'h00, 8'h00, 1'b0, d);
    endtask

    initial begin
        test_reset();
        test_frame_zero();
        test_frame_ff5a();
        test_random_frames();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
